// File: rtl/dither_pkg.sv
// Shared constants and types for the RGB error-diffusion ditherer.
package dither_pkg;

    function automatic int err_w(input int d);
        return d + 2;
    endfunction

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_D = 4;
    typedef logic signed [err_w(DEF_D)-1:0] err_t;

endpackage

// File: rtl/dither_channel.sv
// One colour channel: residual add, threshold rounding, rail saturation
// and the signed residual register carried to the next pixel.
module dither_channel
    import dither_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4,
    parameter int D     = IN_W - OUT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   vis,
    input  logic                   clr,
    input  logic [IN_W-1:0]        pix,
    input  logic [D-1:0]           thr,
    output logic [OUT_W-1:0]       q,
    output logic signed [err_w(D)-1:0] err_q
);

    localparam int EW   = err_w(D);
    localparam int SW   = IN_W + 2;
    localparam int QW   = SW - D;
    localparam int MAXQ = (1 << OUT_W) - 1;

    logic signed [EW-1:0] e_use;
    logic signed [SW-1:0] sum;
    logic        [SW-1:0] diff;
    logic        [QW-1:0] qr;
    logic                 up;
    logic                 neg;
    logic                 hi;
    logic [OUT_W-1:0]     q_n;
    logic [EW-1:0]        err_n;
    logic                 unused;

    always_comb begin
        e_use = clr ? '0 : err_q;
        sum   = $signed({2'b00, pix}) + $signed({{(SW-EW){e_use[EW-1]}}, e_use});
        up    = (sum[D-1:0] >= thr);
        qr    = sum[SW-1:D] + QW'(up);
        neg   = sum[SW-1];
        hi    = !neg && (qr > QW'(MAXQ));
        diff  = sum - {qr, {D{1'b0}}};
        q_n   = qr[OUT_W-1:0];
        err_n = diff[EW-1:0];
        // rails: clamp and drop the residual so it cannot wind up
        if (neg) begin
            q_n   = '0;
            err_n = '0;
        end else if (hi) begin
            q_n   = OUT_W'(MAXQ);
            err_n = '0;
        end
    end

    assign unused = ^diff[SW-1:EW];

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            err_q <= '0;
        end else if (en && vis) begin
            q     <= q_n;
            err_q <= err_n;
        end else if (en) begin
            q     <= '0;
            err_q <= '0;
        end else if (clr) begin
            err_q <= '0;
        end
    end

endmodule

// File: rtl/dither_rgb_pipe.sv
// Multi-channel 1-D error-diffusion ditherer, one cycle latency.
// Define DITHER_NOISE_EN to jitter the rounding threshold from an LFSR.
module dither_rgb_pipe
    import dither_pkg::*;
#(
    parameter int N_CH  = 3,
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    in_valid,
    input  logic                    in_visible,
    input  logic [N_CH*IN_W-1:0]    in_pixel,
    output logic                    out_valid,
    output logic                    out_visible,
    output logic [N_CH*OUT_W-1:0]   out_pixel
);

    localparam int D = IN_W - OUT_W;
    localparam logic [D-1:0] THR_MID = D'(1) << (D-1);

    logic px_en;
    assign px_en = in_valid && in_visible;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_visible <= 1'b0;
        end else begin
            out_valid   <= in_valid;
            out_visible <= px_en;
        end
    end

`ifdef DITHER_NOISE_EN
    logic [15:0] lfsr;
    logic        fb;

    if (N_CH * D > 16) begin : g_bad_cfg
        $error("dither_rgb_pipe: N_CH*D exceeds LFSR width");
    end

    assign fb = ^(lfsr & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (px_en) begin
            lfsr <= {lfsr[14:0], fb};
        end
    end
`endif

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [D-1:0] thr;
`ifdef DITHER_NOISE_EN
        assign thr = lfsr[c*D +: D];
`else
        assign thr = THR_MID;
`endif
        dither_channel #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W),
            .D     (D)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .en    (in_valid),
            .vis   (in_visible),
            .clr   (frame_start),
            .pix   (in_pixel[c*IN_W +: IN_W]),
            .thr   (thr),
            .q     (out_pixel[c*OUT_W +: OUT_W]),
            .err_q ()
        );
    end

endmodule
